mem_bus_ctrl: RTL
=================

Name: mem_bus_ctrl

Overview:
- Sequencer directly upstream of the 256x8 RAM.
- Accepts read/write requests on a valid/ready handshake.
- Generates the RAM strobes (we, MEMBUS, BUSMEM) and address.
- Drives or releases the shared bidirectional data bus, captures read data and returns one response pulse per request.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, data bus width.
- RD_WAIT, 1, cycles MEMBUS is held high before read capture (min 1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept (high only in IDLE)
- req_we  input  1  1=write, 0=read
- req_addr  input  ADDR_WIDTH  request address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle completion pulse (read or write)
- rsp_rdata  output  DATA_WIDTH  last read data, registered
- busy  output  1  high whenever state != IDLE
- mem_addr  output  ADDR_WIDTH  RAM address
- mem_data  inout  DATA_WIDTH  shared RAM data bus
- mem_we  output  1  RAM write enable (0 = read)
- mem_membus  output  1  RAM output enable
- mem_busmem  output  1  RAM input enable

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active-low.
- On reset:
  - state = IDLE.
  - All outputs and registers are 0: req_ready, rsp_valid, rsp_rdata, busy, mem_addr, mem_we, mem_membus, mem_busmem.
  - mem_data is Z.
  - req_ready rises after rst_n deasserts, in IDLE.
- Accept: req_valid && req_ready at a rising edge. On that edge, register addr, we and wdata.
- States: IDLE, RD_SETUP, RD_EN, WR_SETUP, WR_COMMIT, RESP.
- IDLE:
  - req_ready = 1.
  - Bus released: mem_we = mem_membus = mem_busmem = 0, mem_data = Z.
  - Accept with we=0 -> RD_SETUP; accept with we=1 -> WR_SETUP.
- RD_SETUP (1 cycle): mem_addr valid, mem_we = 0, mem_membus = 0, mem_data = Z. -> RD_EN.
- RD_EN (RD_WAIT cycles, down-counter):
  - mem_membus = 1; its rising edge makes the RAM load its output register.
  - On the edge leaving the last RD_EN cycle, rsp_rdata <= mem_data. -> RESP.
- WR_SETUP (1 cycle): mem_addr valid, mem_we = 1, mem_data driven with wdata, mem_busmem = 0. -> WR_COMMIT.
- WR_COMMIT (1 cycle): mem_we = 1, mem_busmem = 1, data still driven; the RAM writes on the edge ending this cycle. -> RESP.
- RESP (1 cycle):
  - rsp_valid = 1, all strobes 0, mem_data = Z. -> IDLE.
  - mem_addr holds its last value.
- Latency, counted from the accept edge:
  - Read: rsp_valid in cycle RD_WAIT+2.
  - Write: rsp_valid in cycle 3.
  - Throughput: one request per RD_WAIT+3 cycles (read) or 4 cycles (write).
- Bus rules:
  - mem_data is driven only in WR_SETUP and WR_COMMIT.
  - mem_membus and mem_we are never both 1.
  - mem_busmem is 1 only in WR_COMMIT.
- rsp_rdata holds its value through writes and idle time; it changes only on read capture.
- Requests presented while busy are ignored (req_ready = 0). Inputs sampled only at the accept edge; later changes have no effect.
- Reset mid-operation: strobes drop and mem_data goes Z immediately (asynchronous). No rsp_valid is produced.
  - Reset during WR_SETUP or WR_COMMIT before the commit edge: no write occurs.
- Addresses 0x00..0xFF are all legal; no wrap logic is needed.

Decomposition:
- Package mem_bus_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - State encoding localparams: IDLE=0, RD_SETUP=1, RD_EN=2, WR_SETUP=3, WR_COMMIT=4, RESP=5.
  - RD_WAIT counter width.
- One natural sub-module, bus_tristate: drive enable plus output data -> inout, with read-back of bus value. It is shared with the other bus masters.

Test Plan:
- Write 0xA5 to 0x10, then read 0x10 -> write rsp_valid 3 cycles after accept; read rsp_valid 3 cycles after accept (RD_WAIT=1) with rsp_rdata = 0xA5; no cycle with mem_we && mem_membus.
- Read preloaded 0xFF from RAM init -> returns init value; mem_data undriven by the controller throughout the read.
- Hold req_valid high for 10 cycles with alternating addr → only one accept per op; ready low until IDLE; inputs changed mid-op have no effect on mem_addr.
- Assert rst_n low during WR_COMMIT for a write of 0x3C to 0x20 → strobes drop immediately, bus Z, no rsp_valid; subsequent read of 0x20 returns the old value.
- Read 0x01 (value 0x11), then write 0x77 to 0x02 → rsp_rdata stays 0x11 after the write response.
- RD_WAIT=3, read 0x40 → mem_membus high exactly 3 cycles; rsp_valid in cycle 5 after accept with correct data.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the RAM bus sequencer: default widths, FSM state
// encoding and the read-wait counter width.
package mem_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  // Counter holds RD_WAIT-1, so RD_WAIT up to 256 fits.
  localparam int RD_CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETUP  = 3'd1,
    RD_EN     = 3'd2,
    WR_SETUP  = 3'd3,
    WR_COMMIT = 3'd4,
    RESP      = 3'd5
  } state_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Request/response handshake between a client (master) and the RAM
// sequencer (slave).
interface mem_bus_ctrl_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/mem_bus_ctrl_bus_tristate.sv
// Tristate bus driver with read-back; shared by every master of the RAM bus.
module bus_tristate #(
  parameter int WIDTH = 8
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] bus
);

   assign bus = oe ? dout : 'z;
   assign din = bus;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequencer in front of the 256x8 RAM: turns valid/ready requests into
// RAM strobe sequences and returns one response pulse per request.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_WAIT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_bus_ctrl_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  mem_membus,
  output logic                  mem_busmem
);

   localparam logic [RD_CNT_W-1:0] RD_LOAD = RD_CNT_W'(RD_WAIT - 1);

   state_t                state, nxt;
   logic [RD_CNT_W-1:0]   cnt;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] bus_in;
   logic                  drive_en;
   logic                  accept;

   assign accept = bus.req_valid && bus.req_ready;

   bus_tristate #(.WIDTH(DATA_WIDTH)) u_tri (
      .oe   (drive_en),
      .dout (wdata_q),
      .din  (bus_in),
      .bus  (mem_data)
   );

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:      if (accept) nxt = bus.req_we ? WR_SETUP : RD_SETUP;
         RD_SETUP:  nxt = RD_EN;
         RD_EN:     if (cnt == '0) nxt = RESP;
         WR_SETUP:  nxt = WR_COMMIT;
         WR_COMMIT: nxt = RESP;
         RESP:      nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state register yet stay glitch-free on the RAM strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         mem_addr      <= '0;
         wdata_q       <= '0;
         bus.rsp_rdata <= '0;
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.busy      <= 1'b0;
         mem_we        <= 1'b0;
         mem_membus    <= 1'b0;
         mem_busmem    <= 1'b0;
         drive_en      <= 1'b0;
      end else begin
         state <= nxt;
         if (state == RD_SETUP)
            cnt <= RD_LOAD;
         else if (state == RD_EN && cnt != '0)
            cnt <= cnt - 1'b1;
         if (accept) begin
            mem_addr <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
         end
         if (state == RD_EN && cnt == '0)
            bus.rsp_rdata <= bus_in;
         bus.req_ready <= (nxt == IDLE);
         bus.rsp_valid <= (nxt == RESP);
         bus.busy      <= (nxt != IDLE);
         mem_we        <= (nxt == WR_SETUP) || (nxt == WR_COMMIT);
         drive_en      <= (nxt == WR_SETUP) || (nxt == WR_COMMIT);
         mem_membus    <= (nxt == RD_EN);
         mem_busmem    <= (nxt == WR_COMMIT);
      end
   end

endmodule
